// File: rtl/alu_pkg.sv
// Shared types and default widths for the accumulator CPU datapath slice.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    PASS_A = 3'b000,
    PASS_B = 3'b001,
    ADD    = 3'b010,
    SUB    = 3'b011,
    AND_OP = 3'b100,
    OR_OP  = 3'b101,
    XOR_OP = 3'b110,
    NOT_A  = 3'b111
  } alu_op_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU with zero and carry/borrow flags; no clock, no state.
module dp_alu
  import alu_pkg::*;
#(
  parameter int DWIDTH = DATA_W
) (
  input  logic [DWIDTH-1:0] alu_a,
  input  logic [DWIDTH-1:0] alu_b,
  input  logic [2:0]        alu_cntl,
  output logic [DWIDTH-1:0] alu_result,
  output logic              alu_zero,
  output logic              alu_carry
);

  alu_op_t          op;
  logic [DWIDTH:0]  wide;

  assign op = alu_op_t'(alu_cntl);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wide       = '0;
    alu_result = alu_a;
    alu_carry  = 1'b0;
    unique case (op)
      PASS_A: alu_result = alu_a;
      PASS_B: alu_result = alu_b;
      ADD: begin
        wide       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = wide[DWIDTH-1:0];
        alu_carry  = wide[DWIDTH];
      end
      SUB: begin
        // The extra top bit goes high exactly when the subtraction wraps, i.e. A < B.
        wide       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = wide[DWIDTH-1:0];
        alu_carry  = wide[DWIDTH];
      end
      AND_OP: alu_result = alu_a & alu_b;
      OR_OP:  alu_result = alu_a | alu_b;
      XOR_OP: alu_result = alu_a ^ alu_b;
      NOT_A:  alu_result = ~alu_a;
    endcase
  end

  assign alu_zero = (alu_result == '0);

endmodule

// File: rtl/alu_dmem.sv
// Datapath slice: combinational ALU plus a register-file data memory with
// asynchronous read, synchronous write and synchronous clear-on-reset.
module alu_dmem
  import alu_pkg::*;
#(
  parameter int DWIDTH = DATA_W,
  parameter int AWIDTH = ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] alu_a,
  input  logic [DWIDTH-1:0] alu_b,
  input  logic [2:0]        alu_cntl,
  output logic [DWIDTH-1:0] alu_result,
  output logic              alu_zero,
  output logic              alu_carry,
  input  logic              mem_we,
  input  logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_wdata,
  output logic [DWIDTH-1:0] mem_rdata
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  dp_alu #(.DWIDTH(DWIDTH)) u_alu (
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cntl   (alu_cntl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry)
  );

  // NOTE: the array is small enough to live in flops, so it is cleared on reset like any other register; state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

endmodule

// File: tb/tb_alu_dmem.sv
// Self-checking bench for alu_dmem: table-driven ALU vectors plus memory sequences.
module tb_alu_dmem;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_cntl;
  logic [3:0] alu_result;
  logic       alu_zero, alu_carry;
  logic       mem_we;
  logic [3:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    alu_op_t    op;
    logic [3:0] result;
    logic       zero;
    logic       carry;
  } vec_t;

  vec_t vecs [16];

  alu_dmem dut (
    .clk        (clk),
    .reset      (reset),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cntl   (alu_cntl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{4'h9, 4'h8, ADD,    4'h1, 1'b0, 1'b1};
    vecs[1]  = '{4'h3, 4'h3, SUB,    4'h0, 1'b1, 1'b0};
    vecs[2]  = '{4'h2, 4'h3, SUB,    4'hF, 1'b0, 1'b1};
    vecs[3]  = '{4'hC, 4'hA, AND_OP, 4'h8, 1'b0, 1'b0};
    vecs[4]  = '{4'hC, 4'hA, OR_OP,  4'hE, 1'b0, 1'b0};
    vecs[5]  = '{4'hC, 4'hA, XOR_OP, 4'h6, 1'b0, 1'b0};
    vecs[6]  = '{4'hC, 4'hA, NOT_A,  4'h3, 1'b0, 1'b0};
    vecs[7]  = '{4'hC, 4'hA, PASS_A, 4'hC, 1'b0, 1'b0};
    vecs[8]  = '{4'hC, 4'hA, PASS_B, 4'hA, 1'b0, 1'b0};
    vecs[9]  = '{4'hF, 4'h1, ADD,    4'h0, 1'b1, 1'b1};
    vecs[10] = '{4'h2, 4'h3, ADD,    4'h5, 1'b0, 1'b0};
    vecs[11] = '{4'hF, 4'h0, NOT_A,  4'h0, 1'b1, 1'b0};
    vecs[12] = '{4'h0, 4'h7, PASS_A, 4'h0, 1'b1, 1'b0};
    vecs[13] = '{4'h0, 4'hF, SUB,    4'h1, 1'b0, 1'b1};
    vecs[14] = '{4'h7, 4'h2, SUB,    4'h5, 1'b0, 1'b0};
    vecs[15] = '{4'h5, 4'h5, XOR_OP, 4'h0, 1'b1, 1'b0};

    reset = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    alu_a = '0; alu_b = '0; alu_cntl = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;

    // ALU table
    foreach (vecs[i]) begin
      alu_a = vecs[i].a; alu_b = vecs[i].b; alu_cntl = vecs[i].op;
      #1;
      check($sformatf("vec%0d_result", i), 32'(alu_result), 32'(vecs[i].result));
      check($sformatf("vec%0d_zero", i),   32'(alu_zero),   32'(vecs[i].zero));
      check($sformatf("vec%0d_carry", i),  32'(alu_carry),  32'(vecs[i].carry));
    end

    // Reset and clear
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 4'd3; mem_wdata = 4'hA;
    @(negedge clk);
    mem_we = 1'b0;
    #1 check("preload_addr3", 32'(mem_rdata), 32'hA);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      mem_addr = 4'(a);
      #1 check($sformatf("clear_addr%0d", a), 32'(mem_rdata), 32'h0);
    end

    // Write timing: old value before the edge, new value after it
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 4'd8; mem_wdata = 4'h5;
    #1 check("wr8_before_edge", 32'(mem_rdata), 32'h0);
    @(posedge clk);
    #1 check("wr8_after_edge", 32'(mem_rdata), 32'h5);
    mem_we = 1'b0;
    mem_addr = 4'd9;
    #1 check("rd9_untouched", 32'(mem_rdata), 32'h0);

    // Second write elsewhere must not disturb addr 8
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 4'd2; mem_wdata = 4'h9;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 4'd8;
    #1 check("rd8_after_wr2", 32'(mem_rdata), 32'h5);
    mem_addr = 4'd2;
    #1 check("rd2", 32'(mem_rdata), 32'h9);

    // Reset beats a write on the same edge
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 4'd4; mem_wdata = 4'h7;
    @(negedge clk);
    mem_we = 1'b0;
    #1 check("preload_addr4", 32'(mem_rdata), 32'h7);
    reset = 1'b1; mem_we = 1'b1; mem_wdata = 4'hF;
    @(negedge clk);
    reset = 1'b0; mem_we = 1'b0;
    #1 check("reset_vs_write_addr4", 32'(mem_rdata), 32'h0);
    mem_addr = 4'd8;
    #1 check("reset_clears_addr8", 32'(mem_rdata), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_dmem.md
# alu_dmem

Combined datapath slice for the 4-bit accumulator CPU: a purely combinational ALU plus a small register-file data memory with combinational read and synchronous write. The CPU control unit drives ALU operand B and the memory address from the instruction operand field. Operand A is driven from the accumulator. The control unit consumes the ALU result and memory read data in the same execute cycle.

## Interface
Parameters:
- DWIDTH, 4, data word width (ALU operands and memory words)
- AWIDTH, 4, memory address width; depth = 2**AWIDTH

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_a  in  DWIDTH  operand A (accumulator)
- alu_b  in  DWIDTH  operand B
- alu_cntl  in  3  ALU operation select
- alu_result  out  DWIDTH  ALU result, combinational
- alu_zero  out  1  high when alu_result == 0
- alu_carry  out  1  carry-out (ADD) or borrow (SUB); 0 for other operations
- mem_we  in  1  write enable
- mem_addr  in  AWIDTH  read/write address
- mem_wdata  in  DWIDTH  write data
- mem_rdata  out  DWIDTH  read data, combinational from mem[mem_addr]

Clock and reset are fixed: one clock; reset is synchronous and active-high.

## Operation
ALU operations (alu_cntl), all results truncated to DWIDTH:
- 000 PASS_A: result = A
  - the CPU uses this as its NOP encoding, so PASS_A must leave the accumulator unchanged
- 001 PASS_B: result = B
- 010 ADD: result = A+B; carry = bit DWIDTH of the (DWIDTH+1)-bit sum
- 011 SUB: result = A−B (mod 2**DWIDTH); carry = 1 when A < B (borrow)
- 100 AND
- 101 OR
- 110 XOR
- 111 NOT_A: result = ~A

ALU flags:
- zero is derived from the final truncated result for every operation.
- carry is 0 for every operation except ADD and SUB.

Data memory:
- 2**AWIDTH words of DWIDTH bits.
- Read is asynchronous: mem_rdata follows mem_addr and current contents with no clock.
- Write: on a rising clk with mem_we=1 and reset=0, mem[mem_addr] <= mem_wdata.

Reset:
- On a rising clk with reset=1, every memory word is cleared to 0.
- Reset has priority over a simultaneous write; the write is discarded.

## Timing
- ALU: zero latency, no internal state, no dependence on clk/reset; outputs valid whenever inputs are stable.
- Output values after reset:
  - mem_rdata = 0 for every address, starting the cycle after reset is sampled.
  - ALU outputs depend only on inputs.
- Write latency: one edge. During the write cycle, mem_rdata at the written address shows the old value. It shows the new value immediately after the edge.
- Read during write to a different address: unaffected.
- Address wrap: not applicable; mem_addr covers exactly the full depth.
- Reset mid-operation:
  - A write pending on the same edge as reset is lost.
  - Memory contents are 0 after that edge regardless of prior writes.
- No handshake; mem_we is sampled only at the rising edge.

## Structure
- Shared package (alu_pkg): alu_op_t enum (3-bit), with the encodings PASS_A…NOT_A above as its literal values, and the default widths DATA_W=4 and ADDR_W=4.
- One sub-module is natural: dp_alu, the combinational ALU with flags. The top instantiates dp_alu.
- The memory array and its reset/write logic live in the top.
- The CPU control unit owns all opcode decoding; this block sees only alu_cntl.

## Test plan
- Reset and clear: write 0xA to addr 3; assert reset for one edge; sweep mem_addr 0..15 -> mem_rdata = 0 at every address.
- Write and read timing: mem_we=1, addr=8, wdata=0x5.
  - Before the edge: mem_rdata = 0.
  - After the edge: mem_rdata = 0x5.
  - Read addr 9: mem_rdata = 0.
- ADD overflow: A=0x9, B=0x8, cntl=010 -> result=0x1, carry=1, zero=0.
- SUB cases:
  - A=3, B=3 -> result=0x0, zero=1, carry=0.
  - A=2, B=3 -> result=0xF, carry=1, zero=0.
- Logic ops: A=0xC, B=0xA.
  - AND -> 0x8
  - OR -> 0xE
  - XOR -> 0x6
  - NOT_A -> 0x3
  - PASS_A -> 0xC
  - PASS_B -> 0xA
  - carry=0 for all of these.
- Reset versus write on the same edge: mem[4]=0x7 pre-loaded; reset=1 and mem_we=1 (addr 4, wdata 0xF) on the same edge -> mem[4]=0 afterwards.
